seq_pattern_detector: RTL and testbench



---
 rtl/seq_det_pkg.sv | 7 +
 rtl/seq_match_counter.sv | 14 +
 rtl/seq_pattern_detector.sv | 91 +++++++++
 tb/tb_seq_pattern_detector.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM states and length-mask helper for the pattern detector
package seq_det_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FILL = 2'd1, ST_RUN = 2'd2} state_t;
   function automatic logic [31:0] len_mask(input int unsigned len);
      return (len >= 32) ? '1 : (32'd1 << len) - 32'd1;
   endfunction
endpackage

// File: rtl/seq_match_counter.sv
// seq_match_counter: saturating event counter with priority clear
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clock)
      if (!resetn || clr) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-programmable serial bit-pattern detector with match counting
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               load,
   input  logic [MAX_LEN-1:0] pat_in,
   input  logic [LEN_W-1:0]   len_in,
   input  logic               overlap_in,
   input  logic               w,
   input  logic               w_valid,
   input  logic               clr_count,
   output logic               match,
   output logic               armed,
   output logic [LEN_W-1:0]   fill_level,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);
   state_t             state, state_n;
   logic [MAX_LEN-1:0] hist, hist_n, pat, pat_n, new_hist;
   logic [LEN_W-1:0]   len_r, len_n, fill_n, new_fill;
   logic               ovl, ovl_n, match_n, cfg_n, legal, accept, hit;

   assign legal    = len_in != '0 && len_in <= LEN_W'(MAX_LEN);
   assign accept   = state != ST_IDLE && w_valid && !load;
   assign new_hist = MAX_LEN'({hist, w});
   assign new_fill = (fill_level == len_r) ? fill_level : fill_level + 1'b1;
   // only the newest len bits take part in the comparison
   assign hit      = new_fill == len_r &&
                     ((32'(new_hist) ^ 32'(pat)) & len_mask(32'(len_r))) == '0;
   assign armed    = state != ST_IDLE;

   always_comb begin
      state_n = state;
      hist_n  = hist;
      fill_n  = fill_level;
      pat_n   = pat;
      len_n   = len_r;
      ovl_n   = ovl;
      cfg_n   = cfg_err;
      match_n = 1'b0;
      if (load) begin
         hist_n  = '0;
         fill_n  = '0;
         cfg_n   = !legal;
         state_n = legal ? ST_FILL : ST_IDLE;
         pat_n   = legal ? pat_in : pat;
         len_n   = legal ? len_in : len_r;
         ovl_n   = legal ? overlap_in : ovl;
      end else if (accept) begin
         match_n = hit;
         hist_n  = (hit && !ovl) ? '0 : new_hist;
         fill_n  = (hit && !ovl) ? '0 : new_fill;
         state_n = (!(hit && !ovl) && new_fill == len_r) ? ST_RUN : ST_FILL;
      end
   end

   always_ff @(posedge clock)
      if (!resetn) begin
         state      <= ST_IDLE;
         hist       <= '0;
         pat        <= '0;
         len_r      <= '0;
         ovl        <= 1'b0;
         fill_level <= '0;
         match      <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         state      <= state_n;
         hist       <= hist_n;
         pat        <= pat_n;
         len_r      <= len_n;
         ovl        <= ovl_n;
         fill_level <= fill_n;
         match      <= match_n;
         cfg_err    <= cfg_n;
      end

   seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock  (clock),
      .resetn (resetn),
      .inc    (match_n),
      .clr    (clr_count),
      .count  (match_count)
   );
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: scoreboard bench against a sliding-window reference model
module tb_seq_pattern_detector;
   localparam int MAX_LEN = 8, LEN_W = 4, CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic resetn = 1'b0, load = 1'b0, overlap_in = 1'b0, w = 1'b0, w_valid = 1'b0, clr_count = 1'b0;
   logic [MAX_LEN-1:0] pat_in = '0;
   logic [LEN_W-1:0]   len_in = '0;
   logic               match, armed, cfg_err;
   logic [LEN_W-1:0]   fill_level;
   logic [CNT_W-1:0]   match_count;

   always #5 clock = ~clock;

   seq_pattern_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .load        (load),
      .pat_in      (pat_in),
      .len_in      (len_in),
      .overlap_in  (overlap_in),
      .w           (w),
      .w_valid     (w_valid),
      .clr_count   (clr_count),
      .match       (match),
      .armed       (armed),
      .fill_level  (fill_level),
      .match_count (match_count),
      .cfg_err     (cfg_err)
   );

   typedef struct packed {
      logic             m;
      logic             a;
      logic             c;
      logic [LEN_W-1:0] f;
      logic [CNT_W-1:0] n;
   } obs_t;

   obs_t expq[$];
   int   vectors = 0, miscompares = 0;

   // reference model: window of accepted bits since the last clear
   bit               win[$];
   logic [MAX_LEN-1:0] m_pat = '0;
   int               m_len = 0, m_cnt = 0;
   bit               m_ovl = 0, m_armed = 0, m_cfg = 0;

   task automatic step(input bit rst, input bit ld, input logic [MAX_LEN-1:0] p, input int l,
                       input bit ov, input bit wb, input bit wv, input bit clr);
      bit hit;
      obs_t e;
      hit = 0;
      @(negedge clock);
      resetn = !rst; load = ld; pat_in = p; len_in = LEN_W'(l);
      overlap_in = ov; w = wb; w_valid = wv; clr_count = clr;
      if (rst) begin
         win.delete(); m_pat = '0; m_len = 0; m_ovl = 0; m_armed = 0; m_cfg = 0; m_cnt = 0;
      end else begin
         if (ld) begin
            win.delete();
            if (l >= 1 && l <= MAX_LEN) begin
               m_pat = p; m_len = l; m_ovl = ov; m_armed = 1; m_cfg = 0;
            end else begin
               m_armed = 0; m_cfg = 1;
            end
         end else if (m_armed && wv) begin
            win.push_back(wb);
            if (win.size() > m_len) void'(win.pop_front());
            if (win.size() == m_len) begin
               hit = 1;
               foreach (win[i]) if (win[i] != m_pat[m_len-1-i]) hit = 0;
            end
            if (hit && !m_ovl) win.delete();
         end
         if (clr) m_cnt = 0;
         else if (hit && m_cnt < CNT_MAX) m_cnt++;
      end
      e.m = hit; e.a = m_armed; e.c = m_cfg; e.f = LEN_W'(win.size()); e.n = CNT_W'(m_cnt);
      expq.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, '0, 0, 0, 0, 0, 0);
   endtask

   task automatic ld(input logic [MAX_LEN-1:0] p, input int l, input bit ov);
      step(0, 1, p, l, ov, 0, 0, 0);
   endtask

   task automatic stream(input logic [31:0] b, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         step(0, 0, '0, 0, 0, b[n-1-i], 1, 0);
         idle(gap);
      end
   endtask

   initial begin
      forever begin
         obs_t e, a;
         @(posedge clock);
         #1;
         if (expq.size() != 0) begin
            e = expq.pop_front();
            a = {match, armed, cfg_err, fill_level, match_count};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL vec %0d: got match=%b armed=%b cfg_err=%b fill=%0d count=%0d, want match=%b armed=%b cfg_err=%b fill=%0d count=%0d",
                        vectors, a.m, a.a, a.c, a.f, a.n, e.m, e.a, e.c, e.f, e.n);
            end
         end
      end
   end

   initial begin
      repeat (2) step(1, 0, '0, 0, 0, 0, 0, 0);
      ld(8'b1101, 4, 1); stream(32'b1101101, 7, 0); idle(1);
      step(0, 0, '0, 0, 0, 0, 0, 1);
      ld(8'b1101, 4, 0); stream(32'b1101101, 7, 0); idle(1);
      ld(8'b111, 3, 1); stream(32'b1111, 4, 2);
      ld(8'b111, 3, 0); stream(32'b1111, 4, 2);
      step(0, 0, '0, 0, 0, 0, 0, 1);
      ld(8'b1, 1, 1); stream(32'b111111, 6, 0);
      step(0, 0, '0, 0, 0, 1, 1, 1);
      ld(8'b0, 1, 0); stream(32'b0010, 4, 0);
      ld(8'b1101, 0, 1); stream(32'b1101, 4, 0);
      ld(8'b1101, 12, 1); stream(32'b1101, 4, 0);
      ld(8'b1101, 4, 1); stream(32'b110, 3, 0);
      step(1, 0, '0, 0, 0, 0, 0, 0);
      stream(32'b1, 1, 0); idle(1);
      ld(8'b10110011, 8, 1); stream(32'b1011001110110011, 16, 0);
      ld(8'b101, 3, 1);
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 1) step(1, 0, '0, 0, 0, 0, 0, 0);
         else if (r < 5)
            step(0, $urandom_range(0, 9) < 7, MAX_LEN'($urandom), ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), 1'($urandom), 0);
         else step(0, 0, '0, 0, 0, 1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      end
      repeat (3) @(negedge clock);
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
